// File: rtl/road_pkg.sv
// road_pkg: shared state encodings, sprite geometry and road window defaults
package road_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BRAKE = 2'b10
  } road_st_t;
  localparam int SPRITE_DIM = 32;
  localparam int SPRITE_AW = 10;
  localparam int PIX_W = 9;
  localparam int SPEED_W_DEF = 3;
  localparam logic [9:0] ROAD_X0_DEF = 10'd192;
  localparam logic [9:0] ROAD_W_DEF = 10'd256;
endpackage

// File: rtl/road_scroll_fsm.sv
// road_scroll_fsm: IDLE/RUN/BRAKE scroll state machine owning speed and scroll_y
module road_scroll_fsm
  import road_pkg::*;
#(
  parameter int SPEED_W = SPEED_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [SPEED_W-1:0] i_speed_in,
  output logic [4:0]         o_scroll_y,
  output logic [SPEED_W-1:0] o_speed,
  output logic [1:0]         o_state
);
  road_st_t r_state, w_state_nx;
  logic [SPEED_W-1:0] r_speed, w_speed_nx;
  logic [4:0] r_scroll, w_scroll_nx;
  logic [4:0] w_step;
  assign w_step = 5'(r_speed);
  always_comb begin
    w_state_nx = r_state;
    w_speed_nx = r_speed;
    w_scroll_nx = r_scroll;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nx = ST_RUN;
          w_speed_nx = i_speed_in;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nx = ST_BRAKE;
        end else if (i_frame_tick) begin
          w_scroll_nx = r_scroll + w_step;
          w_speed_nx = i_speed_in;
        end
      end
      ST_BRAKE: begin
        if (i_frame_tick) begin
          if (r_speed == '0) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_scroll_nx = r_scroll + w_step;
            w_speed_nx = r_speed - SPEED_W'(1);
          end
        end
        if (i_start && !i_stop) begin
          w_state_nx = ST_RUN;
          w_speed_nx = i_speed_in;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_speed <= '0;
      r_scroll <= '0;
    end else begin
      r_state <= w_state_nx;
      r_speed <= w_speed_nx;
      r_scroll <= w_scroll_nx;
    end
  end
  assign o_scroll_y = r_scroll;
  assign o_speed = r_speed;
  assign o_state = r_state;
endmodule

// File: rtl/road_scroll_fetch.sv
// road_scroll_fetch: road window texture address generator with 2-stage pixel alignment
module road_scroll_fetch
  import road_pkg::*;
#(
  parameter logic [9:0] ROAD_X0 = ROAD_X0_DEF,
  parameter logic [9:0] ROAD_W = ROAD_W_DEF,
  parameter int SPEED_W = SPEED_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [9:0]           i_h_cnt,
  input  logic [9:0]           i_v_cnt,
  input  logic                 i_video_on,
  input  logic                 i_frame_tick,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [SPEED_W-1:0]   i_speed_in,
  output logic [SPRITE_AW-1:0] o_ram_addr,
  input  logic [PIX_W-1:0]     i_ram_data,
  output logic [PIX_W-1:0]     o_pix_rgb,
  output logic                 o_pix_valid,
  output logic [4:0]           o_scroll_y,
  output logic [SPEED_W-1:0]   o_speed,
  output logic [1:0]           o_state
);
  logic [4:0] w_scroll_y, w_row, w_col;
  logic w_in_win;
  logic r_win_d1, r_win_d2, r_pix_valid;
  logic [SPRITE_AW-1:0] r_ram_addr;
  logic [PIX_W-1:0] r_pix_rgb;
  road_scroll_fsm #(.SPEED_W(SPEED_W)) u_fsm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_frame_tick(i_frame_tick),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_speed_in  (i_speed_in),
    .o_scroll_y  (w_scroll_y),
    .o_speed     (o_speed),
    .o_state     (o_state)
  );
  assign w_in_win = i_video_on && (i_h_cnt >= ROAD_X0) && (i_h_cnt < ROAD_X0 + ROAD_W);
  assign w_row = 5'(i_v_cnt - {5'd0, w_scroll_y});
  assign w_col = 5'(i_h_cnt - ROAD_X0);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_addr <= '0;
      r_win_d1 <= 1'b0;
      r_win_d2 <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_rgb <= '0;
    end else begin
      r_ram_addr <= {w_row, w_col};
      r_win_d1 <= w_in_win;
      r_win_d2 <= r_win_d1;
      r_pix_valid <= r_win_d2;
      r_pix_rgb <= r_win_d2 ? i_ram_data : '0;
    end
  end
  assign o_ram_addr = r_ram_addr;
  assign o_pix_rgb = r_pix_rgb;
  assign o_pix_valid = r_pix_valid;
  assign o_scroll_y = w_scroll_y;
endmodule

// File: tb/tb_road_scroll_fetch.sv
// tb_road_scroll_fetch: scoreboard bench for road_scroll_fetch with a sprite RAM model
module tb_road_scroll_fetch;
  logic clk = 0, rst_n = 0;
  logic [9:0] h_cnt = 0, v_cnt = 0;
  logic video_on = 0, frame_tick = 0, start = 0, stop = 0;
  logic [2:0] speed_in = 0;
  logic [9:0] ram_addr;
  logic [8:0] ram_data = 0, pix_rgb;
  logic pix_valid;
  logic [4:0] scroll_y;
  logic [2:0] speed;
  logic [1:0] state;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int cyc; logic [9:0] addr;} addr_t;
  typedef struct {int cyc; logic [8:0] rgb;} pix_t;
  addr_t aq[$];
  pix_t pq[$];
  pix_t me;
  road_scroll_fetch dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_h_cnt(h_cnt), .i_v_cnt(v_cnt),
    .i_video_on(video_on), .i_frame_tick(frame_tick), .i_start(start),
    .i_stop(stop), .i_speed_in(speed_in), .o_ram_addr(ram_addr),
    .i_ram_data(ram_data), .o_pix_rgb(pix_rgb), .o_pix_valid(pix_valid),
    .o_scroll_y(scroll_y), .o_speed(speed), .o_state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [8:0] tex(input logic [9:0] a);
    logic [9:0] t;
    t = a * 10'd37 + 10'd11;
    return t[8:0];
  endfunction
  always @(posedge clk) ram_data <= tex(ram_addr);
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (aq.size() > 0 && aq[0].cyc == cyc) begin
      chk("ram_addr", ram_addr, aq[0].addr);
      void'(aq.pop_front());
    end
    if (pix_valid) begin
      if (pq.size() == 0) begin
        chk("pix_valid_unexpected", pix_valid, 0);
      end else begin
        me = pq.pop_front();
        chk("pix_cycle", cyc, me.cyc);
        chk("pix_rgb", pix_rgb, me.rgb);
      end
    end else begin
      chk("pix_rgb_masked", pix_rgb, 0);
      if (pq.size() > 0 && pq[0].cyc <= cyc) begin
        me = pq.pop_front();
        chk("pix_valid_missing", pix_valid, 1);
      end
    end
  end
  task automatic px(input logic [9:0] h, input logic [9:0] v, input logic von,
                    input logic [9:0] ea, input logic ew);
    h_cnt = h;
    v_cnt = v;
    video_on = von;
    aq.push_back('{cyc + 1, ea});
    if (ew) pq.push_back('{cyc + 3, tex(ea)});
    @(posedge clk) #1;
  endtask
  task automatic idle(input int n);
    video_on = 0;
    h_cnt = 0;
    v_cnt = 0;
    repeat (n) @(posedge clk) #1;
  endtask
  task automatic cmd(input logic st, input logic sp, input logic tk);
    start = st;
    stop = sp;
    frame_tick = tk;
    @(posedge clk) #1;
    start = 0;
    stop = 0;
    frame_tick = 0;
  endtask
  task automatic fsm_chk(input string n, input int st, input int sp, input int sc);
    chk({n, "_state"}, state, st);
    chk({n, "_speed"}, speed, sp);
    chk({n, "_scroll"}, scroll_y, sc);
  endtask
  int wrap[5] = '{7, 14, 21, 28, 3};
  int b_sc[4] = '{3, 5, 6, 6};
  int b_sp[4] = '{2, 1, 0, 0};
  int b_st[4] = '{2, 2, 2, 0};
  initial begin
    #12;
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_pix_rgb", pix_rgb, 0);
    chk("rst_pix_valid", pix_valid, 0);
    fsm_chk("rst", 0, 0, 0);
    @(posedge clk) #1 rst_n = 1;
    px(192, 0, 1, 10'h000, 1);
    px(223, 5, 1, 10'h0BF, 1);
    px(224, 5, 1, 10'h0A0, 1);
    px(191, 5, 1, 10'h0BF, 0);
    px(448, 5, 1, 10'h0A0, 0);
    px(447, 31, 1, 10'h3FF, 1);
    px(200, 7, 0, 10'h0E8, 0);
    px(255, 2, 1, 10'h05F, 1);
    idle(5);
    px(200, 3, 1, 10'h068, 1);
    px(201, 3, 1, 10'h069, 1);
    px(202, 3, 1, 10'h06A, 1);
    #1 chk("pre_rst_pix_valid", pix_valid, 1);
    rst_n = 0;
    aq.delete();
    pq.delete();
    #1;
    chk("async_rst_ram_addr", ram_addr, 0);
    chk("async_rst_pix_valid", pix_valid, 0);
    chk("async_rst_pix_rgb", pix_rgb, 0);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1;
    px(210, 4, 1, 10'h092, 1);
    px(211, 4, 1, 10'h093, 1);
    idle(5);
    speed_in = 7;
    cmd(1, 0, 0);
    fsm_chk("start7", 1, 7, 0);
    for (int i = 0; i < 5; i++) begin
      cmd(0, 0, 1);
      chk("wrap_scroll", scroll_y, wrap[i]);
      chk("wrap_speed", speed, 7);
    end
    px(192, 1, 1, 10'h3C0, 1);
    px(200, 1, 1, 10'h3C8, 1);
    idle(5);
    rst_n = 0;
    @(posedge clk) #1 rst_n = 1;
    speed_in = 3;
    cmd(1, 0, 0);
    fsm_chk("run3", 1, 3, 0);
    cmd(0, 1, 0);
    fsm_chk("stop", 2, 3, 0);
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 1);
      fsm_chk("brake", b_st[i], b_sp[i], b_sc[i]);
    end
    speed_in = 2;
    cmd(1, 0, 0);
    fsm_chk("idle_start", 1, 2, 6);
    cmd(1, 1, 0);
    fsm_chk("run_start_stop", 2, 2, 6);
    cmd(1, 1, 0);
    fsm_chk("brake_start_stop", 2, 2, 6);
    speed_in = 5;
    cmd(1, 0, 0);
    fsm_chk("brake_start", 1, 5, 6);
    speed_in = 1;
    idle(3);
    fsm_chk("speed_hold", 1, 5, 6);
    cmd(0, 0, 1);
    fsm_chk("tick_a", 1, 1, 11);
    cmd(0, 0, 1);
    fsm_chk("tick_b", 1, 1, 12);
    speed_in = 4;
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      px(10'(192 + i), 10, 1, 10'(10'h3C0 + i), 1);
      chk("mid_scroll", scroll_y, 12);
    end
    start = 0;
    px(300, 11, 1, 10'h3EC, 1);
    fsm_chk("mid_end", 1, 1, 12);
    idle(5);
    cmd(0, 0, 1);
    fsm_chk("after_mid", 1, 4, 13);
    for (int i = 0; i < 20 && (pq.size() > 0 || aq.size() > 0); i++) @(posedge clk);
    chk("queues_drained", pq.size() + aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/road_scroll_fetch.md
Name: road_scroll_fetch

Overview:
- Sequences the road sprite RAM (32x32 texture, 1024 x 9-bit RGB333, 10-bit address, 1-cycle registered read) for the VGA pixel pipeline.
- Maps each screen pixel inside the road column window to a tiled, vertically scrolling texture address, and realigns the returned pixel with its valid flag.
- Owns the road scroll state: speed, scroll offset, and an IDLE/RUN/BRAKE state machine driven by game start/stop commands.
- Sits between the VGA timing generator and the pixel mux.

Parameters:
ROAD_X0, 10'd192, first screen column of the road window
ROAD_W, 10'd256, road window width in pixels (multiple of 32)
SPEED_W, 3, width of speed value in rows per frame

Ports:
CLK  in  1  system clock (pixel clock domain)
RST_N  in  1  asynchronous, active-low reset
h_cnt  in  10  current VGA column
v_cnt  in  10  current VGA row
video_on  in  1  high in visible area
frame_tick  in  1  one-cycle pulse, once per frame at start of vblank
start  in  1  one-cycle pulse: begin or resume scrolling
stop  in  1  one-cycle pulse: begin braking
speed_in  in  SPEED_W  requested speed, rows per frame
ram_addr  out  10  address to road sprite RAM
ram_data  in  9  road sprite RAM read data (valid one cycle after ram_addr)
pix_rgb  out  9  road pixel, RGB333; 0 when pix_valid low
pix_valid  out  1  pixel lies in road window and video_on
scroll_y  out  5  current vertical texture offset
speed  out  SPEED_W  current applied speed
state  out  2  00 IDLE, 01 RUN, 10 BRAKE

Behaviour:
- Reset (RST_N low, async): state=IDLE, speed=0, scroll_y=0, ram_addr=0, pix_rgb=0, pix_valid=0, and all pipeline flags=0.
- Window: in_win = video_on && h_cnt >= ROAD_X0 && h_cnt < ROAD_X0+ROAD_W. Compare at full 10 bits.
- Address, registered at edge 0: ram_addr = {row, col}.
  - row = (v_cnt[4:0] - scroll_y) mod 32, 5-bit wrap.
  - col = (h_cnt - ROAD_X0)[4:0], so the texture tiles every 32 columns.
  - Outside the window ram_addr still updates; its result is masked.
- Pipeline: in_win is delayed 2 stages.
  - Edge 1: RAM registers data.
  - Edge 2: pix_valid <= in_win_d2; pix_rgb <= in_win_d2 ? ram_data : 0.
  - Fixed latency: coordinates sampled at edge 0 appear at outputs after edge 2. No bubbles, one pixel per clock.
- scroll_y and speed change only on frame_tick (vblank), so no tearing mid-frame.
- FSM, evaluated on every clock:
  - IDLE: start -> RUN, speed <= speed_in. frame_tick has no effect.
  - RUN: stop -> BRAKE, and stop wins over a simultaneous start. On frame_tick without stop: scroll_y <= scroll_y + speed (mod 32), then speed <= speed_in. The new speed applies from the next frame. Speed 0 in RUN is legal: state stays RUN, road is static.
  - BRAKE: start -> RUN with speed <= speed_in; stop+start together keeps BRAKE. On frame_tick: if speed==0 -> IDLE with scroll unchanged; else scroll_y += speed, speed -= 1.
  - Simultaneous command and frame_tick in the same cycle: the state transition and the frame_tick action of the current state both apply. The speed load from start overrides the speed update from frame_tick.
- scroll_y addition is 5-bit modular. speed_in max 7 gives a max step of 7 rows per frame.
- Reset asserted mid-frame clears the pipeline immediately. The next outputs are valid 2 edges after release.

Decomposition:
- Shared package road_pkg:
  - state encodings ST_IDLE/ST_RUN/ST_BRAKE
  - SPRITE_DIM=32, SPRITE_AW=10, PIX_W=9
  - ROAD_X0/ROAD_W defaults
- One natural sub-module, road_scroll_fsm: the FSM plus the speed and scroll_y registers.
- The top level holds the address generator and the 2-stage alignment pipeline, and connects to the existing sprite RAM instance externally.

Test Plan:
- Reset: hold RST_N=0 mid-line -> all outputs 0 asynchronously; release -> pix_valid stays 0 for the first 2 edges.
- Static addressing, scroll_y=0: h=192,v=0 -> ram_addr=0. h=223,v=5 -> ram_addr=0x0BF (row 5, col 31). h=224 -> col 0 again. h=191 or h=448 -> pix_valid=0, pix_rgb=0. RAM model data appears on pix_rgb exactly 2 edges after the coordinates.
- Scroll wrap: start with speed_in=7, apply 5 frame_ticks -> scroll_y 7,14,21,28,3. With scroll_y=3, v=1 -> row=30.
- Braking: RUN at speed 3, scroll 0, pulse stop, then 4 frame_ticks -> scroll 3,5,6,6; speed 2,1,0,0; state BRAKE, BRAKE, BRAKE, IDLE.
- Simultaneous events: start+stop in RUN -> BRAKE. start during BRAKE with speed_in=5 -> RUN, speed=5. speed_in change in RUN takes effect only after the next frame_tick.
- Mid-frame stability: change speed_in and pulse start during the active area -> scroll_y is constant for the whole visible frame, and ram_addr rows are consistent.
